// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key debouncer with press/release/long-press pulses
// Optional auto-repeat pulses are built only when KEY_REPEAT_EN is defined.
module key_debounce #(
  parameter int NUM_KEYS       = 2,
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_PRESS_MS  = 1000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int REPEAT_MS      = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int DB_TICKS     = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_TICKS   = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int REPEAT_TICKS = CLK_FREQ_HZ / 1000 * REPEAT_MS;
  localparam int MAX_A        = (DB_TICKS > LONG_TICKS) ? DB_TICKS : LONG_TICKS;
  localparam int MAX_TICKS    = (MAX_A > REPEAT_TICKS) ? MAX_A : REPEAT_TICKS;
  localparam int CW           = $clog2(MAX_TICKS) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_TICKS);

  localparam logic [NUM_KEYS-1:0] IDLE_PINS = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_PINS;
      sync2_q <= IDLE_PINS;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // XOR with the idle pin level normalises polarity: 1 means pressed.
  assign active = sync2_q ^ IDLE_PINS;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_e        state_q;
    logic [CW-1:0] db_cnt_q, hold_cnt_q;
    logic          level_q, press_q, release_q, long_q;
    logic          pressed_st;

    assign pressed_st = (state_q == S_HELD) || (state_q == S_RELEASE_DB);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_IDLE;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        // Hold time keeps running through release bounce so long fires once.
        if (pressed_st) begin
          if (hold_cnt_q != LONG_MAX) hold_cnt_q <= hold_cnt_q + CNT_ONE;
          long_q <= (hold_cnt_q == LONG_LAST);
        end
        case (state_q)
          S_IDLE: begin
            if (active[k]) begin
              state_q  <= S_PRESS_DB;
              db_cnt_q <= '0;
            end
          end
          S_PRESS_DB: begin
            if (!active[k]) begin
              state_q  <= S_IDLE;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              state_q    <= S_HELD;
              level_q    <= 1'b1;
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              db_cnt_q   <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + CNT_ONE;
            end
          end
          S_HELD: begin
            if (!active[k]) begin
              state_q  <= S_RELEASE_DB;
              db_cnt_q <= '0;
            end
          end
          S_RELEASE_DB: begin
            if (active[k]) begin
              state_q <= S_HELD;
            end else if (db_cnt_q == DB_LAST) begin
              state_q   <= S_IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              db_cnt_q  <= '0;
            end else begin
              db_cnt_q <= db_cnt_q + CNT_ONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TICKS - 1);
    logic [CW-1:0] rep_cnt_q;
    logic          repeat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (!pressed_st) begin
          rep_cnt_q <= '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          rep_cnt_q <= '0;
        end else if (hold_cnt_q == LONG_MAX) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + CNT_ONE;
          end
        end
      end
    end

    assign key_repeat[k] = repeat_q;
`else
    assign key_repeat[k] = 1'b0;
`endif
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-key debouncer and press-event generator that sits directly upstream of the LED pattern controller.
- Takes raw asynchronous push-button pins and synchronises them. Filters contact bounce per key.
- Outputs clean levels plus single-cycle press, release and long-press pulses that downstream LED logic consumes as start/step/mode commands.

Parameters:
- NUM_KEYS, 2, number of independent key channels.
- CLK_FREQ_HZ, 50000000, clk frequency in Hz.
- DEBOUNCE_MS, 20, stable time required to accept a press or release; DB_TICKS = CLK_FREQ_HZ/1000*DEBOUNCE_MS, must be >= 2.
- LONG_PRESS_MS, 1000, held time from press acceptance to long pulse; LONG_TICKS = CLK_FREQ_HZ/1000*LONG_PRESS_MS, must be > DB_TICKS.
- KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- REPEAT_MS, 200, auto-repeat period; used only with KEY_REPEAT_EN; REPEAT_TICKS = CLK_FREQ_HZ/1000*REPEAT_MS.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  NUM_KEYS  raw asynchronous key pins.
- key_level  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle pulse on accepted press.
- key_release  output  NUM_KEYS  1-cycle pulse on accepted release.
- key_long  output  NUM_KEYS  1-cycle pulse once per press at long-press threshold.
- key_repeat  output  NUM_KEYS  1-cycle auto-repeat pulses (KEY_REPEAT_EN only; else constant 0).

Behaviour:
- Reset (async assert, sync release on clk):
  - Synchroniser flops load the inactive pin level.
  - All FSMs go to IDLE. All counters = 0.
  - All outputs = 0.
- Synchronisation: 2-FF synchroniser per key. The active flag is the polarity-normalised synchroniser output.
- Counters: width $clog2(max tick count)+1, sized from parameters; no truncation allowed.
- Channels are fully independent, with no shared counters; simultaneous events on different keys each produce their own pulses in the same cycle.
- Per-key FSM:
  - IDLE:
    - active -> PRESS_DB, db_cnt = 0.
  - PRESS_DB:
    - active and db_cnt < DB_TICKS-1 -> db_cnt++.
    - active and db_cnt == DB_TICKS-1 -> HELD; key_level = 1, key_press = 1 for that cycle, hold_cnt = 0.
    - inactive -> IDLE, db_cnt = 0, no pulse (bounce rejected).
  - HELD:
    - hold_cnt increments each cycle, saturating at LONG_TICKS.
    - key_long pulses in the cycle hold_cnt reaches LONG_TICKS-1; it never fires again for the same press.
    - inactive -> RELEASE_DB, db_cnt = 0.
  - RELEASE_DB:
    - hold_cnt keeps counting.
    - inactive and db_cnt == DB_TICKS-1 -> IDLE; key_level = 0, key_release = 1 for that cycle.
    - active -> HELD (release bounce rejected), hold_cnt not cleared.
- Pulse timing: press/release pulses coincide with the key_level edge. Outputs are registered.
- Latency: key_level and key_press rise DB_TICKS+3 clk edges after key_in settles active (+1 edge for async sampling). Release is symmetric.
- Glitch rule: any glitch shorter than DB_TICKS cycles never changes key_level.
- Reset mid-press: outputs clear immediately with no release pulse. After reset the key is re-qualified from IDLE.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - After key_long, key_repeat pulses every REPEAT_TICKS cycles while the FSM stays in HELD or RELEASE_DB. The first repeat comes REPEAT_TICKS after key_long.
  - Repeat counter clears on entry to IDLE.
  - Each repeat pulse is 1 cycle.
- Undefined: no repeat counter logic is synthesised; key_repeat is tied to 0.

Test Plan:
- All tests use CLK_FREQ_HZ=10000, DEBOUNCE_MS=1 (DB_TICKS=10), LONG_PRESS_MS=5 (LONG_TICKS=50), REPEAT_MS=2 (20), KEY_ACTIVE_LOW=1.
- Reset: hold rst_n=0 with key_in=2'b00 -> all outputs 0. Release rst_n with key_in=2'b11 -> outputs stay 0 for 100 cycles.
- Clean press/release: key_in[0] 1->0 and hold 30 cycles -> key_level[0] rises and key_press[0] pulses 1 cycle at edge 13 (±1). Return to 1 -> key_release[0] pulses 13 (±1) edges later; key_level[0] falls with it.
- Bounce rejection: toggle key_in[0] every 4 cycles for 40 cycles, then hold 1 -> no pulses; key_level stays 0.
- Long press: hold key_in[1]=0 for 100 cycles -> exactly one key_press[1] and one key_long[1], the latter 50 cycles after key_press[1]. A 5-cycle release glitch at cycle 30 produces no extra pulses.
- Simultaneous + reset: press both keys in the same cycle -> both key_press bits pulse together. Assert rst_n=0 mid-hold -> outputs clear at once, no key_release.
- KEY_REPEAT_EN: hold key 0 for 150 cycles -> key_repeat[0] pulses at key_long+20, +40, +60, … until release qualifies. Without the macro, key_repeat stays 0.
